// File: rtl/change_dispenser.sv
// Refund payout engine: latches the customer balance and pays it to the coin hopper
// greedily (5, 1, then 0.5 units), one valid/ack handshake per coin.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       refund_req,
  input  logic [6:0] balance,
  input  logic       half_flag,
  input  logic       hopper_ack,
  input  logic       fault_clr,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [6:0] remain,
  output logic       remain_half,
  output logic [4:0] cnt5,
  output logic [2:0] cnt1,
  output logic       cnt_half
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSel,
    StIssue,
    StGap,
    StDone,
    StFault
  } state_e;

  localparam logic [1:0] CoinNone = 2'b00;
  localparam logic [1:0] CoinHalf = 2'b01;
  localparam logic [1:0] CoinOne  = 2'b10;
  localparam logic [1:0] CoinFive = 2'b11;

  localparam logic [TO_W-1:0] AckTimeout = TO_W'(ACK_TIMEOUT);

  state_e          state_q, state_d;
  logic [1:0]      type_q, type_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [TO_W-1:0] to_inc;
  logic [6:0]      remain_q, remain_d;
  logic            half_q, half_d;
  logic [4:0]      cnt5_q, cnt5_d;
  logic [2:0]      cnt1_q, cnt1_d;
  logic            cnth_q, cnth_d;

  assign to_inc = to_q + TO_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      type_q   <= CoinNone;
      to_q     <= '0;
      remain_q <= '0;
      half_q   <= 1'b0;
      cnt5_q   <= '0;
      cnt1_q   <= '0;
      cnth_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      to_q     <= to_d;
      remain_q <= remain_d;
      half_q   <= half_d;
      cnt5_q   <= cnt5_d;
      cnt1_q   <= cnt1_d;
      cnth_q   <= cnth_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    to_d     = to_q;
    remain_d = remain_q;
    half_d   = half_q;
    cnt5_d   = cnt5_q;
    cnt1_d   = cnt1_q;
    cnth_d   = cnth_q;

    unique case (state_q)
      StIdle: begin
        if (refund_req) begin
          state_d  = StLoad;
          remain_d = balance;
          half_d   = half_flag;
          cnt5_d   = '0;
          cnt1_d   = '0;
          cnth_d   = 1'b0;
        end
      end
      StLoad: state_d = StSel;
      StSel: begin
        to_d = '0;
        if (remain_q >= 7'd5) begin
          type_d  = CoinFive;
          state_d = StIssue;
        end else if (remain_q != 7'd0) begin
          type_d  = CoinOne;
          state_d = StIssue;
        end else if (half_q) begin
          type_d  = CoinHalf;
          state_d = StIssue;
        end else begin
          state_d = StDone;
        end
      end
      StIssue: begin
        // An ack arriving on the final allowed cycle takes priority over the timeout.
        if (hopper_ack) begin
          state_d = StGap;
          case (type_q)
            CoinFive: begin
              remain_d = remain_q - 7'd5;
              cnt5_d   = cnt5_q + 5'd1;
            end
            CoinOne: begin
              remain_d = remain_q - 7'd1;
              cnt1_d   = cnt1_q + 3'd1;
            end
            CoinHalf: begin
              half_d = 1'b0;
              cnth_d = 1'b1;
            end
            default: ;
          endcase
        end else begin
          to_d = to_inc;
          if (to_inc == AckTimeout) state_d = StFault;
        end
      end
      StGap:  state_d = StSel;
      StDone: state_d = StIdle;
      StFault: begin
        if (fault_clr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign coin_valid  = (state_q == StIssue);
  assign coin_type   = coin_valid ? type_q : CoinNone;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign fault       = (state_q == StFault);
  assign remain      = remain_q;
  assign remain_half = half_q;
  assign cnt5        = cnt5_q;
  assign cnt1        = cnt1_q;
  assign cnt_half    = cnth_q;

endmodule
